// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and default sizes for the data-memory arbiter
package dmem_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int MAX_BURST = 8;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way winner select; ports valid_i, state_i, last_grant_i in, win_o (winning port index) out
module dmem_rr_pick (
  input  logic [1:0] valid_i,
  input  logic [1:0] state_i,
  input  logic       last_grant_i,
  output logic       win_o
);
  import dmem_pkg::*;
  // An owner keeps the port while it stays valid; otherwise a tie goes to the port not served last.
  always_comb
    win_o = (state_i == OWN0 && valid_i[0]) ? 1'b0 :
            (state_i == OWN1 && valid_i[1]) ? 1'b1 :
            (&valid_i) ? ~last_grant_i : valid_i[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port single-SRAM arbiter with locked bursts; ports req_* in, req_ready/rsp_* out, SRAM CEN/WEN/A/D/OEN out, Q in
module dmem_arbiter #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int MAX_BURST = dmem_pkg::MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              OEN,
  input  logic [DATA_W-1:0] Q
);
  import dmem_pkg::*;
  localparam int CW = $clog2(MAX_BURST + 1);
  state_e state_q, state_d, own;
  logic last_q, last_d, rd_q, rd_d, win, acc, hold;
  logic [1:0] pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  dmem_rr_pick u_pick (
    .valid_i(req_valid),
    .state_i(state_q),
    .last_grant_i(last_q),
    .win_o(win)
  );
  // The winner is always a valid port, so any valid request means an acceptance; reset masks the combinational path.
  always_comb begin
    acc = rst_n & (|req_valid);
    req_ready = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
    CEN = ~acc;
    WEN = acc ? ~req_we[win] : 1'b1;
    A = acc ? (win ? req_addr1 : req_addr0) : '0;
    D = acc ? (win ? req_wdata1 : req_wdata0) : '0;
    own = win ? OWN1 : OWN0;
    hold = acc && req_lock[win];
    cnt_inc = cnt_q + 1'b1;
    last_d = acc ? win : last_q;
    state_d = IDLE;
    cnt_d = '0;
    if (hold && state_q != own) begin
      state_d = own;
      cnt_d = CW'(1);
    end else if (hold && cnt_inc != CW'(MAX_BURST)) begin
      state_d = own;
      cnt_d = cnt_inc;
    end
    pend_d = req_ready;
    rd_d = acc && !req_we[win];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      pend_q <= '0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      rd_q <= rd_d;
    end
  assign rsp_valid = pend_q;
  assign rsp_rdata = (|pend_q && rd_q) ? Q : '0;
  assign OEN = 1'b0;
endmodule
